decode_stage: RTL and testbench

Instruction decode stage of the RV32E core, sitting between fetch and the executor. It accepts instruction words over a valid/ready handshake and decodes them into a registered bundle (class, register indices, sign-extended immediate, PC). It drives the register file's two read-location inputs and tracks in-flight register writes with a scoreboard, so it only presents an instruction once its operands are up to date.

---
 rtl/rv32e_pkg.sv | 74 +++++++
 rtl/instr_decoder.sv | 80 ++++++++
 rtl/decode_stage.sv | 98 +++++++++
 tb/tb_decode_stage.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32e_pkg.sv
// Shared types for the RV32E front end: instruction classes, opcodes,
// immediate formats and the decoded bundle handed from decode to execute.
package rv32e_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [3:0] {
    CLS_LUI     = 4'd0,
    CLS_AUIPC   = 4'd1,
    CLS_JAL     = 4'd2,
    CLS_JALR    = 4'd3,
    CLS_BRANCH  = 4'd4,
    CLS_LOAD    = 4'd5,
    CLS_STORE   = 4'd6,
    CLS_OP_IMM  = 4'd7,
    CLS_OP      = 4'd8,
    CLS_FENCE   = 4'd9,
    CLS_SYSTEM  = 4'd10,
    CLS_ILLEGAL = 4'd11
  } op_class_t;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } imm_fmt_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HELD  = 1'b1
  } hold_state_t;

  typedef struct packed {
    op_class_t   op_class;
    logic [2:0]  funct3;
    logic        funct7_5;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [31:0] pc;
    logic        uses_rs1;
    logic        uses_rs2;
    logic        writes_rd;
    logic        illegal;
  } decoded_t;

  function automatic logic [31:0] gen_imm(input logic [31:0] w, input imm_fmt_t fmt);
    logic [31:0] imm;
    case (fmt)
      FMT_I:   imm = {{20{w[31]}}, w[31:20]};
      FMT_S:   imm = {{20{w[31]}}, w[31:25], w[11:7]};
      FMT_B:   imm = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      FMT_U:   imm = {w[31:12], 12'b0};
      FMT_J:   imm = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      default: imm = '0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/instr_decoder.sv
// Purely combinational RV32E instruction decoder: opcode table, register
// usage, immediate extraction and illegal-instruction detection.
module instr_decoder
  import rv32e_pkg::*;
#(
  parameter int unsigned NREGS = 16
) (
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  output decoded_t    dec
);

  op_class_t  cls;
  imm_fmt_t   fmt;
  logic       uses_rs1;
  logic       uses_rs2;
  logic       writes_rd;
  logic       bad_reg;
  logic       illegal;
  logic [2:0] funct3;

  assign funct3 = instr[14:12];

  always_comb begin
    cls       = CLS_ILLEGAL;
    fmt       = FMT_R;
    uses_rs1  = 1'b0;
    uses_rs2  = 1'b0;
    writes_rd = 1'b0;
    case (instr[6:0])
      OPC_LUI:    begin cls = CLS_LUI;    fmt = FMT_U; writes_rd = 1'b1; end
      OPC_AUIPC:  begin cls = CLS_AUIPC;  fmt = FMT_U; writes_rd = 1'b1; end
      OPC_JAL:    begin cls = CLS_JAL;    fmt = FMT_J; writes_rd = 1'b1; end
      OPC_JALR:   begin cls = CLS_JALR;   fmt = FMT_I; uses_rs1 = 1'b1; writes_rd = 1'b1; end
      OPC_BRANCH: begin cls = CLS_BRANCH; fmt = FMT_B; uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
      OPC_LOAD:   begin cls = CLS_LOAD;   fmt = FMT_I; uses_rs1 = 1'b1; writes_rd = 1'b1; end
      OPC_STORE:  begin cls = CLS_STORE;  fmt = FMT_S; uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
      OPC_OP_IMM: begin cls = CLS_OP_IMM; fmt = FMT_I; uses_rs1 = 1'b1; writes_rd = 1'b1; end
      OPC_OP: begin
        cls       = CLS_OP;
        fmt       = FMT_R;
        uses_rs1  = 1'b1;
        uses_rs2  = 1'b1;
        writes_rd = 1'b1;
      end
      OPC_FENCE:  begin cls = CLS_FENCE;  fmt = FMT_I; end
      OPC_SYSTEM: begin
        // CSR ops write rd; only the register-source variants (funct3 1..3) read rs1
        cls       = CLS_SYSTEM;
        fmt       = FMT_I;
        writes_rd = (funct3 != 3'b000);
        uses_rs1  = !funct3[2] && (funct3 != 3'b000);
      end
      default: cls = CLS_ILLEGAL;
    endcase
  end

  assign bad_reg = (uses_rs1  && (32'(instr[19:15]) >= NREGS)) ||
                   (uses_rs2  && (32'(instr[24:20]) >= NREGS)) ||
                   (writes_rd && (32'(instr[11:7])  >= NREGS));

  assign illegal = (cls == CLS_ILLEGAL) || (instr[1:0] != 2'b11) || bad_reg;

  always_comb begin
    dec           = '0;
    dec.op_class  = illegal ? CLS_ILLEGAL : cls;
    dec.funct3    = funct3;
    dec.funct7_5  = instr[30];
    dec.rd        = instr[11:7];
    dec.rs1       = instr[19:15];
    dec.rs2       = instr[24:20];
    dec.imm       = illegal ? 32'd0 : gen_imm(instr, fmt);
    dec.pc        = pc;
    dec.uses_rs1  = uses_rs1  && !illegal;
    dec.uses_rs2  = uses_rs2  && !illegal;
    dec.writes_rd = writes_rd && !illegal;
    dec.illegal   = illegal;
  end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: one-entry holding register between fetch and execute, with a
// register scoreboard that withholds instructions until their operands are ready.
module decode_stage
  import rv32e_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 16
) (
  input  logic            clock,
  input  logic            nreset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic [3:0]      read_loc_1,
  output logic [3:0]      read_loc_2,
  output logic            out_valid,
  input  logic            out_ready,
  output decoded_t        out_bundle,
  input  logic            wb_do_write,
  input  logic [3:0]      wb_write_loc,
  input  logic            flush
);

  hold_state_t state_q, state_d;
  decoded_t    bundle_q, bundle_d;
  logic [15:0] busy_q, busy_d;

  decoded_t    dec;
  logic [31:0] in_pc_ext;
  logic        full;
  logic        hazard;
  logic        issue;
  logic        accept;

  assign in_pc_ext = 32'(in_pc);

  instr_decoder #(
    .NREGS (NREGS)
  ) u_instr_decoder (
    .instr (in_instr),
    .pc    (in_pc_ext),
    .dec   (dec)
  );

  assign full = (state_q == ST_HELD);

  // The rd term stalls a second writer until the first has retired (WAW)
  assign hazard = (bundle_q.uses_rs1  && busy_q[bundle_q.rs1[3:0]]) ||
                  (bundle_q.uses_rs2  && busy_q[bundle_q.rs2[3:0]]) ||
                  (bundle_q.writes_rd && busy_q[bundle_q.rd[3:0]]);

  assign out_valid = full && !hazard;
  assign issue     = out_valid && out_ready;
  assign in_ready  = nreset && !flush && (!full || issue);
  assign accept    = in_valid && in_ready;

  assign out_bundle = bundle_q;
  assign read_loc_1 = bundle_q.uses_rs1 ? bundle_q.rs1[3:0] : 4'd0;
  assign read_loc_2 = bundle_q.uses_rs2 ? bundle_q.rs2[3:0] : 4'd0;

  always_comb begin
    state_d  = state_q;
    bundle_d = bundle_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else if (accept) begin
      state_d  = ST_HELD;
      bundle_d = dec;
    end else if (issue) begin
      state_d = ST_EMPTY;
    end
  end

  // Set-on-issue is OR-ed after the clear so a same-cycle collision keeps the bit
  for (genvar gi = 0; gi < 16; gi++) begin : g_busy
    if (gi == 0) begin : g_zero
      assign busy_d[gi] = 1'b0;
    end else begin : g_reg
      assign busy_d[gi] =
          (issue && bundle_q.writes_rd && (bundle_q.rd[3:0] == 4'(gi))) ||
          (busy_q[gi] && !(wb_do_write && (wb_write_loc == 4'(gi))));
    end
  end

  always_ff @(posedge clock) begin
    if (!nreset) begin
      state_q  <= ST_EMPTY;
      bundle_q <= '0;
      busy_q   <= '0;
    end else begin
      state_q  <= state_d;
      bundle_q <= bundle_d;
      busy_q   <= busy_d;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed scenarios plus random traffic, every cycle
// compared against a behavioural model of the stage and its scoreboard.
module tb_decode_stage;
  import rv32e_pkg::*;

  logic        clock = 1'b0;
  logic        nreset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic [3:0]  read_loc_1;
  logic [3:0]  read_loc_2;
  logic        out_valid;
  logic        out_ready;
  decoded_t    out_bundle;
  logic        wb_do_write;
  logic [3:0]  wb_write_loc;
  logic        flush;

  int n_cmp = 0;
  int n_bad = 0;

  // model state: is an instruction held, what it decodes to, which regs are pending
  bit       m_full;
  decoded_t m_b;
  bit       m_pend[16];

  decode_stage #(.XLEN(32), .NREGS(16)) dut (
    .clock        (clock),
    .nreset       (nreset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_instr     (in_instr),
    .in_pc        (in_pc),
    .read_loc_1   (read_loc_1),
    .read_loc_2   (read_loc_2),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_bundle   (out_bundle),
    .wb_do_write  (wb_do_write),
    .wb_write_loc (wb_write_loc),
    .flush        (flush)
  );

  always #5 clock = ~clock;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic decoded_t ref_decode(input logic [31:0] w, input logic [31:0] pc);
    decoded_t    d;
    logic [31:0] sx;
    logic [31:0] imm;
    logic [31:0] i_imm;
    op_class_t   c;
    bit          u1, u2, wr, bad;
    int          f3;
    sx    = $signed(w) >>> 31;
    i_imm = $signed(w) >>> 20;
    f3    = int'(w[14:12]);
    c = CLS_ILLEGAL; u1 = 0; u2 = 0; wr = 0; imm = 0;
    case (w[6:0])
      7'h37: begin c = CLS_LUI;   wr = 1; imm = w & 32'hFFFFF000; end
      7'h17: begin c = CLS_AUIPC; wr = 1; imm = w & 32'hFFFFF000; end
      7'h6F: begin
        c = CLS_JAL; wr = 1;
        imm = (sx << 20) | (32'(w[19:12]) << 12) | (32'(w[20]) << 11) | (32'(w[30:21]) << 1);
      end
      7'h67: begin c = CLS_JALR; u1 = 1; wr = 1; imm = i_imm; end
      7'h63: begin
        c = CLS_BRANCH; u1 = 1; u2 = 1;
        imm = (sx << 12) | (32'(w[7]) << 11) | (32'(w[30:25]) << 5) | (32'(w[11:8]) << 1);
      end
      7'h03: begin c = CLS_LOAD; u1 = 1; wr = 1; imm = i_imm; end
      7'h23: begin c = CLS_STORE; u1 = 1; u2 = 1; imm = (i_imm & ~32'h1F) | 32'(w[11:7]); end
      7'h13: begin c = CLS_OP_IMM; u1 = 1; wr = 1; imm = i_imm; end
      7'h33: begin c = CLS_OP; u1 = 1; u2 = 1; wr = 1; imm = 0; end
      7'h0F: begin c = CLS_FENCE; imm = i_imm; end
      7'h73: begin c = CLS_SYSTEM; imm = i_imm; wr = (f3 != 0); u1 = (f3 >= 1 && f3 <= 3); end
      default: c = CLS_ILLEGAL;
    endcase
    bad = (u1 && w[19]) || (u2 && w[24]) || (wr && w[11]);
    d = '0;
    if (c == CLS_ILLEGAL || w[1:0] != 2'b11 || bad) begin
      d.illegal = 1; c = CLS_ILLEGAL; u1 = 0; u2 = 0; wr = 0; imm = 0;
    end
    d.op_class = c; d.funct3 = w[14:12]; d.funct7_5 = w[30];
    d.rd = w[11:7]; d.rs1 = w[19:15]; d.rs2 = w[24:20];
    d.imm = imm; d.pc = pc; d.uses_rs1 = u1; d.uses_rs2 = u2; d.writes_rd = wr;
    return d;
  endfunction

  // One cycle: drive inputs after the falling edge, compare outputs against the
  // model, then advance the model to what the coming rising edge should produce.
  task automatic step(input bit rst_n, input bit iv, input logic [31:0] ins, input logic [31:0] pc,
                      input bit ordy, input bit wbw, input logic [3:0] wbl, input bit fl);
    bit         h, ov, ir, iss, acc;
    logic [3:0] e1, e2;
    @(negedge clock);
    nreset = rst_n; in_valid = iv; in_instr = ins; in_pc = pc;
    out_ready = ordy; wb_do_write = wbw; wb_write_loc = wbl; flush = fl;
    #2;
    h  = m_full && ((m_b.uses_rs1 && m_pend[m_b.rs1[3:0]]) ||
                    (m_b.uses_rs2 && m_pend[m_b.rs2[3:0]]) ||
                    (m_b.writes_rd && m_pend[m_b.rd[3:0]]));
    ov = m_full && !h;
    ir = rst_n && !fl && (!m_full || (ov && ordy));
    e1 = m_b.uses_rs1 ? m_b.rs1[3:0] : 4'd0;
    e2 = m_b.uses_rs2 ? m_b.rs2[3:0] : 4'd0;
    check("out_valid", 128'(out_valid), 128'(ov));
    check("in_ready", 128'(in_ready), 128'(ir));
    check("read_loc_1", 128'(read_loc_1), 128'(e1));
    check("read_loc_2", 128'(read_loc_2), 128'(e2));
    check("out_bundle", 128'(out_bundle), 128'(m_b));
    if (!rst_n) begin
      m_full = 0; m_b = '0;
      for (int r = 0; r < 16; r++) m_pend[r] = 0;
    end else begin
      iss = ov && ordy;
      acc = iv && ir;
      if (wbw && wbl != 0) m_pend[wbl] = 0;
      if (iss && m_b.writes_rd && m_b.rd != 0) m_pend[m_b.rd[3:0]] = 1;
      if (fl) m_full = 0;
      else if (acc) begin m_full = 1; m_b = ref_decode(ins, pc); end
      else if (iss) m_full = 0;
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 10))
      0: w[6:0] = 7'h37;  1: w[6:0] = 7'h17;  2: w[6:0] = 7'h6F;  3: w[6:0] = 7'h67;
      4: w[6:0] = 7'h63;  5: w[6:0] = 7'h03;  6: w[6:0] = 7'h23;  7: w[6:0] = 7'h13;
      8: w[6:0] = 7'h33;  9: w[6:0] = 7'h0F;  default: w[6:0] = 7'h73;
    endcase
    if ($urandom_range(0, 9) != 0) begin
      w[11:7]  = 5'($urandom_range(0, 7));
      w[19:15] = 5'($urandom_range(0, 7));
      w[24:20] = 5'($urandom_range(0, 7));
    end
    if ($urandom_range(0, 14) == 0) w[6:0] = 7'($urandom);
    return w;
  endfunction

  initial begin
    bit          r_rst, r_iv, r_ordy, r_wbw, r_fl;
    logic [3:0]  r_wbl;
    int          q[$];

    nreset = 0; in_valid = 0; in_instr = 0; in_pc = 0;
    out_ready = 0; wb_do_write = 0; wb_write_loc = 0; flush = 0;
    m_full = 0; m_b = '0;
    for (int r = 0; r < 16; r++) m_pend[r] = 0;
    @(posedge clock);

    // model anchors
    check("ref_addi_imm", ref_decode(32'hFFC18293, 0).imm, 32'hFFFFFFFC);
    check("ref_jal_imm", ref_decode(32'hFFDFF0EF, 0).imm, 32'hFFFFFFFC);
    check("ref_sw_imm", ref_decode(32'hFE512C23, 0).imm, 32'hFFFFFFF8);
    check("ref_add17_ill", 128'(ref_decode(32'h002088B3, 0).illegal), 128'(1));

    // reset then idle
    step(0, 0, 0, 0, 0, 0, 0, 0);
    check("lit_rst_in_ready", 128'(in_ready), 128'(0));
    step(1, 0, 0, 0, 1, 0, 0, 0);
    check("lit_idle_in_ready", 128'(in_ready), 128'(1));
    check("lit_idle_out_valid", 128'(out_valid), 128'(0));
    check("lit_idle_rl1", 128'(read_loc_1), 128'(0));

    // addi x5,x3,-4 with backpressure
    step(1, 1, 32'hFFC18293, 32'h100, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      step(1, 0, 0, 0, 0, 0, 0, 0);
      check("lit_addi_valid", 128'(out_valid), 128'(1));
      check("lit_addi_class", 128'(out_bundle.op_class), 128'(CLS_OP_IMM));
      check("lit_addi_rd", 128'(out_bundle.rd), 128'(5));
      check("lit_addi_rs1", 128'(out_bundle.rs1), 128'(3));
      check("lit_addi_imm", 128'(out_bundle.imm), 128'(32'hFFFFFFFC));
      check("lit_addi_rl1", 128'(read_loc_1), 128'(3));
      check("lit_addi_rl2", 128'(read_loc_2), 128'(0));
      check("lit_bp_in_ready", 128'(in_ready), 128'(0));
    end
    // release: issue addi and accept add x6,x5,x1 together
    step(1, 1, 32'h00128333, 32'h104, 1, 0, 0, 0);
    check("lit_issue_accept", 128'(in_ready), 128'(1));
    for (int k = 0; k < 3; k++) begin
      step(1, 0, 0, 0, 1, 0, 0, 0);
      check("lit_raw_stall", 128'(out_valid), 128'(0));
    end
    step(1, 0, 0, 0, 1, 1, 4'd5, 0);
    check("lit_raw_wb_cycle", 128'(out_valid), 128'(0));
    step(1, 0, 0, 0, 1, 0, 0, 0);
    check("lit_raw_release", 128'(out_valid), 128'(1));

    // illegal: add x17,x1,x2 then opcode 0x7F
    step(1, 1, 32'h002088B3, 32'h108, 1, 0, 0, 0);
    step(1, 1, 32'h0000007F, 32'h10C, 1, 0, 0, 0);
    check("lit_x17_illegal", 128'(out_bundle.illegal), 128'(1));
    check("lit_x17_class", 128'(out_bundle.op_class), 128'(CLS_ILLEGAL));
    check("lit_x17_valid", 128'(out_valid), 128'(1));
    step(1, 0, 0, 0, 1, 0, 0, 0);
    check("lit_7f_class", 128'(out_bundle.op_class), 128'(CLS_ILLEGAL));

    // flush while held; x6 stays busy afterwards
    step(1, 1, 32'h00100393, 32'h110, 0, 0, 0, 0);
    step(1, 1, 32'h00000013, 32'h114, 0, 0, 0, 1);
    check("lit_flush_in_ready", 128'(in_ready), 128'(0));
    step(1, 0, 0, 0, 1, 0, 0, 0);
    check("lit_flush_dropped", 128'(out_valid), 128'(0));
    step(1, 1, 32'h00030433, 32'h118, 1, 0, 0, 0);
    step(1, 0, 0, 0, 1, 0, 0, 0);
    check("lit_busy_kept", 128'(out_valid), 128'(0));
    step(1, 0, 0, 0, 1, 1, 4'd6, 0);
    step(1, 0, 0, 0, 1, 0, 0, 0);
    check("lit_busy_cleared", 128'(out_valid), 128'(1));

    // reset while held
    step(1, 1, 32'h00500113, 32'h11C, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    check("lit_midrst_in_ready", 128'(in_ready), 128'(0));
    step(1, 0, 0, 0, 0, 0, 0, 0);
    check("lit_midrst_valid", 128'(out_valid), 128'(0));
    check("lit_midrst_rl1", 128'(read_loc_1), 128'(0));

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      r_rst  = ($urandom_range(0, 399) != 0);
      r_iv   = ($urandom_range(0, 3) != 0);
      r_ordy = ($urandom_range(0, 3) != 0);
      r_fl   = ($urandom_range(0, 24) == 0);
      r_wbw  = 0;
      r_wbl  = 0;
      if ($urandom_range(0, 2) == 0) begin
        q.delete();
        for (int r = 1; r < 16; r++) if (m_pend[r]) q.push_back(r);
        if (q.size() > 0) begin
          r_wbw = 1;
          r_wbl = 4'(q[$urandom_range(0, q.size() - 1)]);
        end
      end else if ($urandom_range(0, 19) == 0) begin
        r_wbw = 1;
        r_wbl = 4'($urandom_range(0, 15));
      end
      step(r_rst, r_iv, rand_instr(), {$urandom_range(0, 32'h3FFFFFFF), 2'b00}, r_ordy, r_wbw, r_wbl, r_fl);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
